prng_lfsr: RTL and testbench
============================

PRNG_LFSR -- requirements
Module: prng_lfsr

Interface
REQ-001 Parameter WIDTH, default 30: LFSR state width, legal range 3..64.
REQ-002 Parameter POLY, default 30'h00000053: feedback polynomial, where bit k is the coefficient of x^k for k < WIDTH, x^WIDTH is implicit and bit 0 must be 1 (default is x^30+x^6+x^4+x+1).
REQ-003 Parameter MODE, default 0: 0 selects Fibonacci form, 1 selects Galois form.
REQ-004 Parameter OUT_BITS, default 30: width of the rand output, 1..WIDTH.
REQ-005 Parameter WARMUP, default 16: number of discard steps after reset-release enable or seed load, 0..255.
REQ-006 Parameter DEFAULT_SEED, default 1: nonzero state used after reset and substituted for any zero seed.
REQ-007 clk  in  1  single rising-edge clock for all state.
REQ-008 rst_n  in  1  reset, asynchronous and active-low.
REQ-009 en  in  1  generator enable, level-sensitive.
REQ-010 seed_load  in  1  one-cycle strobe that loads seed_in.
REQ-011 seed_in  in  WIDTH  seed value, sampled when seed_load=1.
REQ-012 rand  out  OUT_BITS  current sample, equal to state bits [OUT_BITS-1:0] at capture.
REQ-013 rand_valid  out  1  rand holds an unconsumed sample.
REQ-014 rand_ready  in  1  consumer accepts rand when rand_valid=1 and rand_ready=1.
REQ-015 period_wrap  out  1  one-cycle pulse when the stepped state equals the last loaded seed.

Function
REQ-016 Galois step SHALL be next = {s[W-2:0],0} XOR (s[W-1] ? POLY : 0).
REQ-017 Fibonacci step SHALL be next = {s[W-2:0], fb}, where fb = s[W-1] XOR the XOR of s[k-1] for every k in 1..W-1 with POLY[k]=1.
REQ-018 The FSM SHALL have three states: IDLE, WARMUP and RUN.
REQ-019 In IDLE, the state SHALL hold and not step; en=1 SHALL move to WARMUP, or to RUN if WARMUP=0.
REQ-020 In WARMUP, the state SHALL step every cycle and warm_cnt SHALL increment, with no samples produced; at warm_cnt=WARMUP-1 the FSM SHALL move to RUN.
REQ-021 In RUN, when rand_valid=0 or rand_ready=1: rand <= s[OUT_BITS-1:0], rand_valid <= 1, and the state steps once in the same cycle.
REQ-022 In RUN, when rand_valid=1 and rand_ready=0, rand and the state SHALL hold unchanged; no sample is lost and none is duplicated.
REQ-023 First rand_valid SHALL assert WARMUP+1 cycles after IDLE sees en=1; with continuous ready, one new sample SHALL be produced per cycle.
REQ-024 en=0 in WARMUP or RUN SHALL move the FSM to IDLE next cycle, clear rand_valid and warm_cnt, and retain the LFSR state.
REQ-025 seed_load SHALL take priority over every other event: the state loads seed_in (DEFAULT_SEED if seed_in=0), the seed register updates, rand_valid and warm_cnt clear, and the next FSM state is WARMUP (or RUN if WARMUP=0) if en=1, else IDLE.
REQ-026 seed_load coincident with a handshake SHALL discard the handshake's step; the accepted sample counts as consumed.
REQ-027 period_wrap SHALL pulse in the cycle after a step whose result equals the seed register, in both WARMUP and RUN.
REQ-028 The state SHALL never become zero; if it does through an upset, the next cycle SHALL load DEFAULT_SEED.

Reset
REQ-029 rst_n=0 SHALL immediately force: state=DEFAULT_SEED, seed register=DEFAULT_SEED, FSM=IDLE, warm_cnt=0, rand=0, rand_valid=0, period_wrap=0.
REQ-030 Assertion of rst_n mid-WARMUP or mid-RUN SHALL abandon the pending sample with no partial output.
REQ-031 After rst_n rises, the first step SHALL occur no earlier than the first clk edge with en=1.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the MODE constants, and the default POLY table for widths 4, 8, 16, 30, 32 and 64.
REQ-033 The step function SHALL be a combinational sub-module lfsr_step (WIDTH, POLY, MODE); the FSM and handshake logic SHALL live in prng_lfsr.

Verification
REQ-034 Galois, WIDTH=4, POLY=4'h3, seed_load 4'h1, WARMUP=0, ready=1 -> rand sequence 1,2,4,8,3,6,C,B and period_wrap after 15 steps.
REQ-035 Fibonacci, WIDTH=4, POLY=4'h3, seed 4'h1 -> all 15 nonzero values each appear once, and period_wrap pulses exactly every 15 steps.
REQ-036 seed_load with seed_in=0 -> state=DEFAULT_SEED and rand_valid=0 next cycle.
REQ-037 Defaults, en=1 after reset, ready=1 -> first rand_valid 17 cycles after en, then valid on every cycle.
REQ-038 rand_ready held low for 5 cycles in RUN -> rand stable for those 5 cycles, and the next value equals the step of the held state.
REQ-039 rst_n pulsed low mid-RUN -> rand_valid=0 and rand=0 immediately; after release, behaviour identical to power-on.

Source files
------------

// File: rtl/prng_lfsr_pkg.sv
// Shared definitions for the LFSR pseudo-random generator: FSM states, step-form
// selectors and a table of maximal-length feedback polynomials.
package prng_lfsr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   localparam int unsigned MODE_FIBONACCI = 0;
   localparam int unsigned MODE_GALOIS    = 1;

   // Low-order coefficients only; x^width is implicit. Unlisted widths fall back to x^w+x+1.
   function automatic logic [63:0] default_poly(input int unsigned width);
      case (width)
         4:       return 64'h0000_0000_0000_0003;
         8:       return 64'h0000_0000_0000_001D;
         16:      return 64'h0000_0000_0000_002D;
         30:      return 64'h0000_0000_0000_0053;
         32:      return 64'h0000_0000_0000_00C5;
         64:      return 64'h0000_0000_0000_001B;
         default: return 64'h0000_0000_0000_0003;
      endcase
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step LFSR update in either Fibonacci or Galois form.
module lfsr_step
   import prng_lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 30,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
   parameter int unsigned      MODE  = MODE_FIBONACCI
) (
   input  logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] state_next
);

   logic fb;

   always_comb begin
      fb = state[WIDTH-1];
      for (int unsigned k = 1; k < WIDTH; k++) begin
         if (POLY[k]) fb = fb ^ state[k-1];
      end
      if (MODE == MODE_GALOIS) begin
         state_next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? POLY : '0);
      end else begin
         state_next = {state[WIDTH-2:0], fb};
      end
   end

endmodule

// File: rtl/prng_lfsr.sv
// LFSR pseudo-random generator with seed loading, warm-up discard, a valid/ready
// sample interface and a period-wrap indicator.
module prng_lfsr
   import prng_lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH        = 30,
   parameter logic [WIDTH-1:0] POLY         = WIDTH'(default_poly(WIDTH)),
   parameter int unsigned      MODE         = MODE_FIBONACCI,
   parameter int unsigned      OUT_BITS     = 30,
   parameter int unsigned      WARMUP       = 16,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                seed_load,
   input  logic [WIDTH-1:0]    seed_in,
   output logic [OUT_BITS-1:0] rand_data,
   output logic                rand_valid,
   input  logic                rand_ready,
   output logic                period_wrap
);

   localparam logic [7:0] WARM_LAST   = 8'(WARMUP - 1);
   localparam state_t     START_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

   state_t           fsm, fsm_next;
   logic [WIDTH-1:0] lfsr, lfsr_stepped, seed_reg, seed_value;
   logic [7:0]       warm_cnt;
   logic             take, step;

   lfsr_step #(
      .WIDTH(WIDTH),
      .POLY (POLY),
      .MODE (MODE)
   ) u_step (
      .state     (lfsr),
      .state_next(lfsr_stepped)
   );

   always_comb begin
      seed_value = (seed_in == '0) ? DEFAULT_SEED : seed_in;
   end

   always_comb begin
      fsm_next = fsm;
      take     = 1'b0;
      step     = 1'b0;
      if (seed_load) begin
         fsm_next = en ? START_STATE : ST_IDLE;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (en) fsm_next = START_STATE;
            end
            ST_WARMUP: begin
               if (!en) begin
                  fsm_next = ST_IDLE;
               end else begin
                  step = 1'b1;
                  if (warm_cnt == WARM_LAST) fsm_next = ST_RUN;
               end
            end
            ST_RUN: begin
               if (!en) begin
                  fsm_next = ST_IDLE;
               end else if (!rand_valid || rand_ready) begin
                  take = 1'b1;
                  step = 1'b1;
               end
            end
            default: fsm_next = ST_IDLE;
         endcase
      end
      // A zeroed state is repaired instead of stepped or sampled.
      if (lfsr == '0) begin
         take = 1'b0;
         step = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm         <= ST_IDLE;
         lfsr        <= DEFAULT_SEED;
         seed_reg    <= DEFAULT_SEED;
         warm_cnt    <= '0;
         rand_data   <= '0;
         rand_valid  <= 1'b0;
         period_wrap <= 1'b0;
      end else begin
         fsm         <= fsm_next;
         period_wrap <= 1'b0;
         warm_cnt    <= (fsm == ST_WARMUP && fsm_next == ST_WARMUP) ? warm_cnt + 8'd1 : '0;
         if (seed_load) begin
            lfsr       <= seed_value;
            seed_reg   <= seed_value;
            rand_valid <= 1'b0;
            warm_cnt   <= '0;
         end else begin
            if (lfsr == '0) begin
               lfsr <= DEFAULT_SEED;
            end else if (step) begin
               lfsr        <= lfsr_stepped;
               period_wrap <= (lfsr_stepped == seed_reg);
            end
            if (take) begin
               rand_data  <= lfsr[OUT_BITS-1:0];
               rand_valid <= 1'b1;
            end else if (fsm_next != ST_RUN || rand_ready) begin
               rand_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_prng_lfsr.sv
// Self-checking bench for prng_lfsr: default 30-bit Fibonacci build plus 4-bit
// Galois and Fibonacci builds, checked against an arithmetic LFSR model.
module tb_prng_lfsr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        en_d, sl_d, ready_d, valid_d, wrap_d;
   logic [29:0] seed_d, rand_d;
   logic        en_g, sl_g, ready_g, valid_g, wrap_g;
   logic [3:0]  seed_g, rand_g;
   logic        en_f, sl_f, ready_f, valid_f, wrap_f;
   logic [3:0]  seed_f, rand_f;

   int checks = 0;
   int errors = 0;
   logic [63:0] ms;
   logic [63:0] mrand;

   prng_lfsr dut_def (
      .clk(clk), .rst_n(rst_n), .en(en_d), .seed_load(sl_d), .seed_in(seed_d),
      .rand_data(rand_d), .rand_valid(valid_d), .rand_ready(ready_d), .period_wrap(wrap_d)
   );

   prng_lfsr #(
      .WIDTH(4), .POLY(4'h3), .MODE(1), .OUT_BITS(4), .WARMUP(0), .DEFAULT_SEED(4'h1)
   ) dut_gal (
      .clk(clk), .rst_n(rst_n), .en(en_g), .seed_load(sl_g), .seed_in(seed_g),
      .rand_data(rand_g), .rand_valid(valid_g), .rand_ready(ready_g), .period_wrap(wrap_g)
   );

   prng_lfsr #(
      .WIDTH(4), .POLY(4'h3), .MODE(0), .OUT_BITS(4), .WARMUP(0), .DEFAULT_SEED(4'h1)
   ) dut_fib (
      .clk(clk), .rst_n(rst_n), .en(en_f), .seed_load(sl_f), .seed_in(seed_f),
      .rand_data(rand_f), .rand_valid(valid_f), .rand_ready(ready_f), .period_wrap(wrap_f)
   );

   // Galois: multiply by x modulo P(x)=x^w+poly. Fibonacci: shift in the parity of the taps.
   function automatic logic [63:0] ref_next(input int unsigned w, input logic [63:0] poly,
                                            input bit galois, input logic [63:0] s);
      logic [64:0] t;
      logic [63:0] mask, taps;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      if (galois) begin
         t = {1'b0, s} << 1;
         if (t[w]) t = t ^ ({1'b0, poly} | (65'd1 << w));
         return t[63:0] & mask;
      end
      taps = (poly >> 1) | (64'd1 << (w - 1));
      return ((s << 1) | 64'(^(s & taps))) & mask;
   endfunction

   function automatic logic [63:0] def_next(input logic [63:0] s);
      return ref_next(30, 64'h53, 1'b0, s);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      en_d = 0; sl_d = 0; seed_d = '0; ready_d = 0;
      en_g = 0; sl_g = 0; seed_g = '0; ready_g = 0;
      en_f = 0; sl_f = 0; seed_f = '0; ready_f = 0;
      repeat (2) @(negedge clk);
      checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_d); end
      checks++; if (rand_d !== 30'h0) begin errors++; $display("FAIL reset_rand: got %h expected 0", rand_d); end
      checks++; if (wrap_d !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap_d); end
      checks++; if ({valid_g, rand_g, valid_f, rand_f} !== 10'h0) begin
         errors++; $display("FAIL reset_small: got %b%h %b%h expected zeros", valid_g, rand_g, valid_f, rand_f);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({valid_d, wrap_d} !== 2'b00) begin
         errors++; $display("FAIL idle_no_output: got valid=%b wrap=%b expected 0 0", valid_d, wrap_d);
      end
   endtask

   task automatic test_galois();
      logic [63:0] s;
      logic [3:0]  exp_seq [8];
      exp_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB};
      sl_g = 1; seed_g = 4'h1; en_g = 1; ready_g = 1;
      @(negedge clk);
      sl_g = 0;
      checks++; if ({valid_g, wrap_g} !== 2'b00) begin
         errors++; $display("FAIL gal_after_load: got valid=%b wrap=%b expected 0 0", valid_g, wrap_g);
      end
      s = 64'h1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         checks++; if ({valid_g, rand_g} !== {1'b1, s[3:0]}) begin
            errors++; $display("FAIL gal_model k=%0d: got valid=%b rand=%h expected 1 %h", k, valid_g, rand_g, s[3:0]);
         end
         if (k <= 8) begin
            checks++; if (rand_g !== exp_seq[k-1]) begin
               errors++; $display("FAIL gal_table k=%0d: got %h expected %h", k, rand_g, exp_seq[k-1]);
            end
         end
         checks++; if (wrap_g !== (k == 15)) begin
            errors++; $display("FAIL gal_wrap k=%0d: got %b expected %b", k, wrap_g, (k == 15));
         end
         s = ref_next(4, 64'h3, 1'b1, s);
      end
      en_g = 0;
   endtask

   task automatic test_fibonacci();
      logic [63:0] s;
      int seen [16];
      int bad;
      foreach (seen[i]) seen[i] = 0;
      sl_f = 1; seed_f = 4'h1; en_f = 1; ready_f = 1;
      @(negedge clk);
      sl_f = 0;
      s = 64'h1;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (k <= 15) seen[rand_f]++;
         checks++; if ({valid_f, rand_f} !== {1'b1, s[3:0]}) begin
            errors++; $display("FAIL fib_model k=%0d: got valid=%b rand=%h expected 1 %h", k, valid_f, rand_f, s[3:0]);
         end
         checks++; if (wrap_f !== (k % 15 == 0)) begin
            errors++; $display("FAIL fib_wrap k=%0d: got %b expected %b", k, wrap_f, (k % 15 == 0));
         end
         s = ref_next(4, 64'h3, 1'b0, s);
      end
      bad = (seen[0] != 0) ? 1 : 0;
      for (int v = 1; v < 16; v++) if (seen[v] != 1) bad++;
      checks++; if (bad != 0) begin
         errors++; $display("FAIL fib_coverage: got %0d bad value counts expected 0", bad);
      end
      en_f = 0;
   endtask

   // Measures en-to-first-valid latency from the current IDLE state, then streams with ready high.
   task automatic test_warmup_latency(input logic [63:0] start_state);
      int lat;
      ms = start_state;
      repeat (16) ms = def_next(ms);
      en_d = 1; ready_d = 1;
      lat = 0;
      @(negedge clk);
      while (valid_d !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (lat != 17) begin errors++; $display("FAIL warmup_latency: got %0d expected 17", lat); end
      mrand = ms; ms = def_next(ms);
      checks++; if (rand_d !== mrand[29:0]) begin
         errors++; $display("FAIL first_sample: got %h expected %h", rand_d, mrand[29:0]);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         mrand = ms; ms = def_next(ms);
         checks++; if ({valid_d, rand_d} !== {1'b1, mrand[29:0]}) begin
            errors++; $display("FAIL stream i=%0d: got valid=%b rand=%h expected 1 %h", i, valid_d, rand_d, mrand[29:0]);
         end
      end
   endtask

   task automatic test_backpressure();
      ready_d = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if ({valid_d, rand_d} !== {1'b1, mrand[29:0]}) begin
            errors++; $display("FAIL hold i=%0d: got valid=%b rand=%h expected 1 %h", i, valid_d, rand_d, mrand[29:0]);
         end
      end
      ready_d = 1;
      @(negedge clk);
      checks++; if (rand_d !== def_next(mrand)) begin
         errors++; $display("FAIL after_hold: got %h expected %h", rand_d, def_next(mrand));
      end
      mrand = ms; ms = def_next(ms);
   endtask

   task automatic test_zero_seed();
      int early;
      sl_d = 1; seed_d = '0; ready_d = 1;
      @(negedge clk);
      sl_d = 0;
      checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL zero_seed_valid: got %b expected 0", valid_d); end
      ms = 64'h1;
      early = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (valid_d !== 1'b0) early++;
         ms = def_next(ms);
      end
      checks++; if (early != 0) begin errors++; $display("FAIL zero_seed_warmup: got %0d early samples expected 0", early); end
      @(negedge clk);
      mrand = ms; ms = def_next(ms);
      checks++; if ({valid_d, rand_d} !== {1'b1, mrand[29:0]}) begin
         errors++; $display("FAIL zero_seed_first: got valid=%b rand=%h expected 1 %h", valid_d, rand_d, mrand[29:0]);
      end
   endtask

   task automatic test_enable_pause();
      logic [63:0] retained;
      retained = ms;
      en_d = 0;
      @(negedge clk);
      checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL pause_valid: got %b expected 0", valid_d); end
      repeat (2) @(negedge clk);
      checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL pause_idle: got %b expected 0", valid_d); end
      test_warmup_latency(retained);
   endtask

   task automatic test_random_flow();
      logic [63:0] s, mseed, mr;
      logic        mvalid, mwrap, sl, rdy;
      logic [29:0] sd;
      int          warm;
      s = '0; mseed = '0; mr = '0; mvalid = 0; warm = 0;
      for (int c = 0; c < 300; c++) begin
         sl  = (c == 0) || ($urandom_range(0, 39) == 0);
         sd  = ($urandom_range(0, 3) == 0) ? 30'h0 : 30'($urandom);
         rdy = 1'($urandom_range(0, 1));
         sl_d = sl; seed_d = sd; ready_d = rdy;
         @(negedge clk);
         mwrap = 0;
         if (sl) begin
            s = (sd == 30'h0) ? 64'h1 : {34'h0, sd};
            mseed = s; mvalid = 0; warm = 16;
         end else if (warm > 0) begin
            s = def_next(s); mwrap = (s == mseed); warm--;
         end else if (!mvalid || rdy) begin
            mr = s; mvalid = 1; s = def_next(s); mwrap = (s == mseed);
         end
         checks++; if ({valid_d, wrap_d} !== {mvalid, mwrap}) begin
            errors++; $display("FAIL rand_flags c=%0d: got valid=%b wrap=%b expected %b %b", c, valid_d, wrap_d, mvalid, mwrap);
         end
         if (mvalid) begin
            checks++; if (rand_d !== mr[29:0]) begin
               errors++; $display("FAIL rand_data c=%0d: got %h expected %h", c, rand_d, mr[29:0]);
            end
         end
      end
      sl_d = 0; ready_d = 1;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", valid_d); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({valid_d, rand_d, wrap_d} !== 32'h0) begin
         errors++; $display("FAIL async_reset: got valid=%b rand=%h wrap=%b expected zeros", valid_d, rand_d, wrap_d);
      end
      en_d = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", valid_d); end
      test_warmup_latency(64'h1);
   endtask

   initial begin
      test_reset();
      test_galois();
      test_fibonacci();
      test_warmup_latency(64'h1);
      test_backpressure();
      test_zero_seed();
      test_enable_pause();
      test_random_flow();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
